// File: rtl/fibo_pkg.sv
// Shared types and defaults for the Fibonacci/Lucas sequence generator.
// Holds the controller state encoding and the default index width.
package fibo_pkg;

   localparam int COUNT_W_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fibo_step.sv
// One recurrence step: sum = a + b, with carry-out and optional clamping.
// Purely combinational; the owner registers the result.
module fibo_step #(
   parameter int WIDTH    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] w_full;

   assign w_full = {1'b0, a} + {1'b0, b};
   assign carry  = w_full[WIDTH];

   // Clamp to all-ones on carry when saturating, otherwise keep the low bits.
   assign sum = (SATURATE && w_full[WIDTH]) ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];

endmodule

// File: rtl/fibonacci_seq.sv
// Programmable-seed sequence generator emitting n_terms terms over a
// valid/ready stream, with sticky overflow detection and abort support.
module fibonacci_seq
   import fibo_pkg::*;
#(
   parameter int             WIDTH    = 32,
   parameter int             COUNT_W  = COUNT_W_DEFAULT,
   parameter logic [WIDTH-1:0] SEED_A = '0,
   parameter logic [WIDTH-1:0] SEED_B = WIDTH'(1),
   parameter bit             SATURATE = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   seed_a,
   input  logic [WIDTH-1:0]   seed_b,
   input  logic               start,
   input  logic [COUNT_W-1:0] n_terms,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   term,
   output logic [COUNT_W-1:0] index,
   output logic               busy,
   output logic               done,
   output logic               overflow
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_seed_a;
   logic [WIDTH-1:0]   r_seed_b;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [COUNT_W-1:0] r_index;
   logic [COUNT_W-1:0] r_remaining;
   logic               r_valid;
   logic               r_busy;
   logic               r_done;
   logic               r_overflow;

   logic [WIDTH-1:0]   w_sum;
   logic               w_carry;
   logic               w_fire;

   fibo_step #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_step (
      .a     (r_a),
      .b     (r_b),
      .sum   (w_sum),
      .carry (w_carry)
   );

   assign w_fire = r_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_seed_a    <= SEED_A;
         r_seed_b    <= SEED_B;
         r_a         <= SEED_A;
         r_b         <= SEED_B;
         r_index     <= '0;
         r_remaining <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // load takes precedence over a same-cycle start
               if (load) begin
                  r_seed_a <= seed_a;
                  r_seed_b <= seed_b;
               end else if (start) begin
                  r_busy <= 1'b1;
                  if (n_terms != '0) begin
                     r_a         <= r_seed_a;
                     r_b         <= r_seed_b;
                     r_index     <= '0;
                     r_remaining <= n_terms;
                     r_overflow  <= 1'b0;
                     r_valid     <= 1'b1;
                     r_state     <= RUN;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            RUN: begin
               // abort wins over a same-cycle handshake; overflow is kept
               if (abort) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_fire) begin
                  r_a         <= r_b;
                  r_b         <= w_sum;
                  r_index     <= r_index + COUNT_W'(1);
                  r_remaining <= r_remaining - COUNT_W'(1);
                  if (w_carry) begin
                     r_overflow <= 1'b1;
                  end
                  if (r_remaining == COUNT_W'(1)) begin
                     r_valid <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign term      = r_a;
   assign index     = r_index;
   assign busy      = r_busy;
   assign done      = r_done;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fibonacci_seq.sv
// Drives a wrapping and a saturating 8-bit generator with identical stimulus
// and compares both against an integer reference of the sequence rules.
module tb_fibonacci_seq;

   localparam int W  = 8;
   localparam int CW = 16;
   localparam int MAXN = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          load;
   logic [W-1:0]  seed_a;
   logic [W-1:0]  seed_b;
   logic          start;
   logic [CW-1:0] n_terms;
   logic          abort;
   logic          out_ready;
   logic [1:0]    out_valid;
   logic [1:0]    busy;
   logic [1:0]    done;
   logic [1:0]    overflow;
   logic [W-1:0]  term [2];
   logic [CW-1:0] idx  [2];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         fibonacci_seq #(
            .WIDTH    (W),
            .COUNT_W  (CW),
            .SEED_A   (8'd0),
            .SEED_B   (8'd1),
            .SATURATE (gi == 1)
         ) dut (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .seed_a    (seed_a),
            .seed_b    (seed_b),
            .start     (start),
            .n_terms   (n_terms),
            .abort     (abort),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready),
            .term      (term[gi]),
            .index     (idx[gi]),
            .busy      (busy[gi]),
            .done      (done[gi]),
            .overflow  (overflow[gi])
         );
      end
   endgenerate

   int n_tests = 0;
   int n_fail  = 0;

   // reference state: current seeds and expected / observed sequences
   int seed_a_m = 0;
   int seed_b_m = 1;
   int exp_term [2][MAXN];
   bit ovf_pref [2][MAXN+1];
   int obs_term [2][MAXN];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Sequence from the rules: t0=A, t1=B, t(k+2)=t(k)+t(k+1) wrapped or clamped;
   // overflow after k accepted terms = any of the first k sums exceeded 8 bits.
   task automatic build_model(input int n);
      for (int d = 0; d < 2; d++) begin
         int x = seed_a_m;
         int y = seed_b_m;
         ovf_pref[d][0] = 1'b0;
         for (int k = 0; k < n; k++) begin
            int raw = x + y;
            int nxt;
            exp_term[d][k] = x;
            if (raw > 255) nxt = (d == 1) ? 255 : raw % 256;
            else           nxt = raw;
            ovf_pref[d][k+1] = ovf_pref[d][k] | (raw > 255);
            x = y;
            y = nxt;
         end
      end
   endtask

   task automatic do_load(input int a, input int b);
      load   = 1'b1;
      start  = 1'b1;
      n_terms = 16'd5;
      seed_a = W'(a);
      seed_b = W'(b);
      @(negedge clk);
      load  = 1'b0;
      start = 1'b0;
      seed_a_m = a;
      seed_b_m = b;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("load_no_start_busy[%0d]", d), busy[d], 1'b0);
         chk($sformatf("load_no_start_valid[%0d]", d), out_valid[d], 1'b0);
      end
   endtask

   // mode 0: always ready; 1: random ready plus ignored start/load noise;
   // 2: ready low for 3 cycles at index 4. abort_at < 0 disables abort.
   task automatic run_seq(input int n, input int mode, input int abort_at);
      int k = 0;
      int cyc = 0;
      int stall = 0;
      bit r;
      build_model(n);
      start   = 1'b1;
      n_terms = CW'(n);
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("n0_done[%0d]", d), done[d], 1'b1);
            chk($sformatf("n0_valid[%0d]", d), out_valid[d], 1'b0);
            chk($sformatf("n0_busy[%0d]", d), busy[d], 1'b1);
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("n0_done_drop[%0d]", d), done[d], 1'b0);
            chk($sformatf("n0_idle[%0d]", d), busy[d], 1'b0);
         end
         $display("[TB] run n=0 mode=%0d", mode);
         return;
      end
      while (k < n) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid[%0d]@%0d", d, k), out_valid[d], 1'b1);
            chk($sformatf("term[%0d]@%0d", d, k), term[d], exp_term[d][k]);
            chk($sformatf("index[%0d]@%0d", d, k), idx[d], k);
            chk($sformatf("busy[%0d]@%0d", d, k), busy[d], 1'b1);
            chk($sformatf("done_low[%0d]@%0d", d, k), done[d], 1'b0);
            chk($sformatf("ovf[%0d]@%0d", d, k), overflow[d], ovf_pref[d][k]);
            obs_term[d][k] = int'(term[d]);
         end
         if (k == abort_at) begin
            abort     = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            load  = 1'b0;
            for (int d = 0; d < 2; d++) begin
               chk($sformatf("abort_valid[%0d]", d), out_valid[d], 1'b0);
               chk($sformatf("abort_busy[%0d]", d), busy[d], 1'b0);
               chk($sformatf("abort_done[%0d]", d), done[d], 1'b0);
               chk($sformatf("abort_ovf[%0d]", d), overflow[d], ovf_pref[d][k]);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++)
               chk($sformatf("abort_no_done[%0d]", d), done[d], 1'b0);
            $display("[TB] run n=%0d aborted at index %0d", n, k);
            return;
         end
         if (mode == 1)                      r = 1'($urandom_range(1, 0));
         else if (mode == 2 && k == 4 && stall < 3) begin
            r = 1'b0;
            stall++;
         end else                            r = 1'b1;
         out_ready = r;
         if (mode == 1) begin
            start   = ($urandom_range(3, 0) == 0);
            load    = ($urandom_range(3, 0) == 0);
            n_terms = CW'($urandom_range(40, 0));
            seed_a  = W'($urandom);
            seed_b  = W'($urandom);
         end
         @(negedge clk);
         if (r) k++;
         cyc++;
         if (cyc > 2000) begin
            chk("run_timeout", cyc, 0);
            break;
         end
      end
      start = 1'b0;
      load  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("end_done[%0d]", d), done[d], 1'b1);
         chk($sformatf("end_valid[%0d]", d), out_valid[d], 1'b0);
         chk($sformatf("end_busy[%0d]", d), busy[d], 1'b1);
         chk($sformatf("end_ovf[%0d]", d), overflow[d], ovf_pref[d][n]);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("post_done[%0d]", d), done[d], 1'b0);
         chk($sformatf("post_busy[%0d]", d), busy[d], 1'b0);
      end
      $display("[TB] run n=%0d mode=%0d seeds=%0d,%0d cycles=%0d", n, mode, seed_a_m, seed_b_m, cyc);
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_valid[%0d]", tag, d), out_valid[d], 1'b0);
         chk($sformatf("%s_index[%0d]", tag, d), idx[d], 0);
         chk($sformatf("%s_busy[%0d]", tag, d), busy[d], 1'b0);
         chk($sformatf("%s_done[%0d]", tag, d), done[d], 1'b0);
         chk($sformatf("%s_ovf[%0d]", tag, d), overflow[d], 1'b0);
         chk($sformatf("%s_term[%0d]", tag, d), term[d], 0);
      end
   endtask

   initial begin
      int fib10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
      int lucas [6]  = '{2, 1, 3, 4, 7, 11};
      rst = 1'b1; load = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      seed_a = '0; seed_b = '0; n_terms = '0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      run_seq(10, 0, -1);
      for (int k = 0; k < 10; k++) chk($sformatf("fib10@%0d", k), obs_term[0][k], fib10[k]);

      run_seq(16, 0, -1);
      chk("wrap_idx13", obs_term[0][13], 233);
      chk("wrap_idx14", obs_term[0][14], 121);
      chk("sat_idx14", obs_term[1][14], 255);
      chk("sat_idx15", obs_term[1][15], 255);

      run_seq(10, 2, -1);
      run_seq(10, 0, 3);
      run_seq(0, 0, -1);

      do_load(2, 1);
      run_seq(6, 0, -1);
      for (int k = 0; k < 6; k++) chk($sformatf("lucas@%0d", k), obs_term[0][k], lucas[k]);
      run_seq(6, 1, -1);
      for (int k = 0; k < 6; k++) chk($sformatf("lucas_rerun@%0d", k), obs_term[0][k], lucas[k]);

      start = 1'b1; n_terms = 16'd10; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrun_rst");
      rst = 1'b0;
      seed_a_m = 0;
      seed_b_m = 1;
      @(negedge clk);
      chk_reset_vals("after_rst");
      run_seq(5, 0, -1);

      for (int i = 0; i < 20; i++) begin
         do_load($urandom_range(255, 0), $urandom_range(255, 0));
         run_seq($urandom_range(40, 1), 1, ($urandom_range(4, 0) == 0) ? $urandom_range(8, 0) : -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
